// File: rtl/rx_buf_arb.sv
// Round-robin arbiter that owns the rx buffer read port on behalf of three requesters.
// Each tenure is capped at MAX_HOLD grant cycles, and read data is tagged back to its owner.
module rx_buf_arb #(
  parameter int unsigned MAX_HOLD = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [10:0] raddr0,
  input  logic [10:0] raddr1,
  input  logic [10:0] raddr2,
  output logic [2:0]  gnt,
  output logic        rx_buf_rden,
  output logic [10:0] rx_buf_raddr,
  input  logic [7:0]  rx_buf_rdata,
  output logic [7:0]  rdata,
  output logic [2:0]  rdata_vld,
  output logic        hold_timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [10:0] HOLD_LAST = 11'(MAX_HOLD - 1);

  state_t      state_r, state_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [1:0]  owner_r, owner_s;
  logic [10:0] hold_r, hold_s;
  logic [2:0]  gnt_r, gnt_s;
  logic        rden_r, rden_s;
  logic [10:0] raddr_r, raddr_s;
  logic        timeout_r, timeout_s;
  logic [2:0]  vld_r;
  logic        own_req_s;
  logic [10:0] own_addr_s;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nx;
    case (idx)
      2'd0:    nx = 2'd1;
      2'd1:    nx = 2'd2;
      default: nx = 2'd0;
    endcase
    return nx;
  endfunction

  // Search order ptr, ptr+1, ptr+2; pointer code 3 behaves as 0.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] base, i1, i2, win;
    base = (p == 2'd3) ? 2'd0 : p;
    i1   = next_idx(base);
    i2   = next_idx(i1);
    if (r[base]) begin
      win = base;
    end else if (r[i1]) begin
      win = i1;
    end else begin
      win = i2;
    end
    return win;
  endfunction

  // Request and address of the current owner.
  always_comb begin
    own_req_s  = 1'b0;
    own_addr_s = 11'd0;
    case (owner_r)
      2'd0:    begin own_req_s = req[0]; own_addr_s = raddr0; end
      2'd1:    begin own_req_s = req[1]; own_addr_s = raddr1; end
      2'd2:    begin own_req_s = req[2]; own_addr_s = raddr2; end
      default: begin own_req_s = 1'b0;   own_addr_s = 11'd0;  end
    endcase
  end

  // Next-state and next-output logic; every tenure ends in IDLE so handovers always see a gap.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    hold_s    = hold_r;
    gnt_s     = 3'b000;
    rden_s    = 1'b0;
    raddr_s   = 11'd0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 3'b000) begin
          owner_s = pick(req, ptr_r);
          gnt_s   = onehot3(owner_s);
          hold_s  = 11'd0;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!own_req_s) begin
          state_s = IDLE;
          ptr_s   = next_idx(owner_r);
        end else if (hold_r == HOLD_LAST) begin
          state_s   = IDLE;
          ptr_s     = next_idx(owner_r);
          timeout_s = 1'b1;
        end else begin
          gnt_s   = onehot3(owner_r);
          rden_s  = 1'b1;
          raddr_s = own_addr_s;
          hold_s  = hold_r + 11'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; owner_r is stable while a read is in flight, so it tags rdata_vld.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      owner_r   <= 2'd0;
      hold_r    <= 11'd0;
      gnt_r     <= 3'b000;
      rden_r    <= 1'b0;
      raddr_r   <= 11'd0;
      timeout_r <= 1'b0;
      vld_r     <= 3'b000;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      hold_r    <= hold_s;
      gnt_r     <= gnt_s;
      rden_r    <= rden_s;
      raddr_r   <= raddr_s;
      timeout_r <= timeout_s;
      vld_r     <= rden_r ? onehot3(owner_r) : 3'b000;
    end
  end

  assign gnt          = gnt_r;
  assign rx_buf_rden  = rden_r;
  assign rx_buf_raddr = raddr_r;
  assign rdata        = rx_buf_rdata;
  assign rdata_vld    = vld_r;
  assign hold_timeout = timeout_r;

endmodule

// File: tb/tb_rx_buf_arb.sv
// Scoreboard bench for rx_buf_arb: directed arbitration scenarios, mid-tenure reset and random stress.
module tb_rx_buf_arb;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [10:0] raddr0, raddr1, raddr2;
  logic [2:0]  gnt;
  logic        rx_buf_rden;
  logic [10:0] rx_buf_raddr;
  logic [7:0]  rx_buf_rdata;
  logic [7:0]  rdata;
  logic [2:0]  rdata_vld;
  logic        hold_timeout;

  rx_buf_arb #(.MAX_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .gnt(gnt), .rx_buf_rden(rx_buf_rden), .rx_buf_raddr(rx_buf_raddr),
    .rx_buf_rdata(rx_buf_rdata), .rdata(rdata), .rdata_vld(rdata_vld),
    .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [10:0] a);
    return a[7:0] ^ 8'h5a ^ {5'd0, a[10:8]};
  endfunction

  // Synchronous-read RAM stand-in.
  logic [7:0] ram_q;
  always @(posedge clk) if (rx_buf_rden) ram_q <= mem_f(rx_buf_raddr);
  assign rx_buf_rdata = ram_q;

  typedef struct {
    logic [2:0]  who;
    logic [10:0] addr;
    int          due;
  } sb_t;
  sb_t sb_q[$];

  int n_vec = 0, n_err = 0, cyc = 0, n_to = 0, run_len = 0;
  int want[3];
  int vld_cnt[3];
  logic [10:0] addr_ctr[3];
  logic [31:0] log_sig;
  logic [2:0]  prev_gnt;
  bit          rnd_addr;
  bit          m_grant, m_rden, m_to;
  int          m_owner, m_ptr, m_hold;
  logic [2:0]  m_gnt;
  logic [10:0] m_raddr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    sb_t e;
    cyc++;
    check_eq("gnt", 32'(gnt), 32'(m_gnt));
    check_eq("rden", 32'(rx_buf_rden), 32'(m_rden));
    check_eq("raddr", 32'(rx_buf_raddr), 32'(m_raddr));
    check_eq("hold_to", 32'(hold_timeout), 32'(m_to));
    check_eq("gnt_1hot", 32'($onehot0(gnt)), 32'd1);
    check_eq("handover", 32'(prev_gnt != 3'b000 && gnt != 3'b000 && gnt != prev_gnt), 32'd0);
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check_eq("vld", 32'(rdata_vld), 32'(e.who));
      check_eq("rdata", 32'(rdata), 32'(mem_f(e.addr)));
    end else begin
      check_eq("vld_idle", 32'(rdata_vld), 32'd0);
    end
    for (int i = 0; i < 3; i++) if (rdata_vld[i]) vld_cnt[i]++;
    if (hold_timeout) n_to++;
    if (gnt != 3'b000) begin
      run_len++;
    end else begin
      if (hold_timeout) check_eq("tenure_len", 32'(run_len), 32'(HOLD));
      run_len = 0;
    end
    prev_gnt = gnt;
  endtask

  // Drive requests for the coming edge and predict what that edge produces.
  task automatic drive_and_predict();
    int w;
    sb_t e;
    if (rnd_addr) for (int i = 0; i < 3; i++) addr_ctr[i] = 11'($urandom_range(0, 2047));
    for (int i = 0; i < 3; i++) req[i] = (want[i] != 0);
    raddr0 = addr_ctr[0];
    raddr1 = addr_ctr[1];
    raddr2 = addr_ctr[2];
    m_to = 1'b0;
    if (!m_grant) begin
      m_rden  = 1'b0;
      m_raddr = 11'd0;
      m_gnt   = 3'b000;
      if (req != 3'b000) begin
        w = -1;
        for (int k = 0; k < 3; k++) if (w < 0 && req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        m_grant = 1'b1;
        m_owner = w;
        m_hold  = 0;
        m_gnt   = 3'(1 << w);
        log_sig = (log_sig << 4) | 32'(w + 1);
      end
    end else if (!req[m_owner] || m_hold == HOLD - 1) begin
      m_to    = req[m_owner];
      m_grant = 1'b0;
      m_gnt   = 3'b000;
      m_rden  = 1'b0;
      m_raddr = 11'd0;
      m_ptr   = (m_owner + 1) % 3;
    end else begin
      m_rden  = 1'b1;
      m_raddr = addr_ctr[m_owner];
      m_hold++;
      e.who  = 3'(1 << m_owner);
      e.addr = addr_ctr[m_owner];
      e.due  = cyc + 2;
      sb_q.push_back(e);
      if (want[m_owner] > 0) want[m_owner]--;
      addr_ctr[m_owner] = addr_ctr[m_owner] + 11'd1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_and_predict();
  endtask

  function automatic bit all_idle();
    return !m_grant && want[0] == 0 && want[1] == 0 && want[2] == 0 && sb_q.size() == 0;
  endfunction

  task automatic drain(input string tag, input int max);
    for (int k = 0; k < max && !all_idle(); k++) cycle();
    check_eq(tag, 32'(all_idle()), 32'd1);
    cycle();
  endtask

  task automatic clear_model();
    m_grant = 1'b0; m_rden = 1'b0; m_to = 1'b0;
    m_owner = 0; m_ptr = 0; m_hold = 0;
    m_gnt = 3'b000; m_raddr = 11'd0;
    prev_gnt = 3'b000; run_len = 0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) want[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_rden"}, 32'(rx_buf_rden), 32'd0);
    check_eq({tag, "_raddr"}, 32'(rx_buf_raddr), 32'd0);
    check_eq({tag, "_vld"}, 32'(rdata_vld), 32'd0);
    check_eq({tag, "_to"}, 32'(hold_timeout), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = 3'b000;
    raddr0 = 11'd0; raddr1 = 11'd0; raddr2 = 11'd0;
    rnd_addr = 1'b0; log_sig = 32'd0;
    for (int i = 0; i < 3; i++) begin
      addr_ctr[i] = 11'(i * 256);
      vld_cnt[i] = 0;
    end
    clear_model();
    #1;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // All three request 4 reads each: grants 0,1,2 with a gap.
    want[0] = 4; want[1] = 4; want[2] = 4; log_sig = 32'd0;
    drain("s1_done", 100);
    check_eq("s1_order", log_sig, 32'h123);
    for (int i = 0; i < 3; i++) check_eq("s1_vld_cnt", 32'(vld_cnt[i]), 32'd4);

    // Lone requester 1, latency from request to data.
    for (int i = 0; i < 3; i++) vld_cnt[i] = 0;
    want[1] = 4; addr_ctr[1] = 11'h010;
    cycle();
    cycle(); check_eq("s2_gnt", 32'(gnt), 32'h2);
    cycle(); check_eq("s2_rden", 32'(rx_buf_rden), 32'd1);
             check_eq("s2_raddr", 32'(rx_buf_raddr), 32'h010);
    cycle(); check_eq("s2_vld", 32'(rdata_vld), 32'h2);
             check_eq("s2_rdata", 32'(rdata), 32'(mem_f(11'h010)));
    drain("s2_done", 40);
    check_eq("s2_vld_cnt", 32'(vld_cnt[1]), 32'd4);

    // Requester 0 holds forever, is cut off, 2 gets a turn, then 0 again.
    log_sig = 32'd0; n_to = 0; want[0] = -1;
    for (int k = 0; k < 10 && gnt != 3'b001; k++) cycle();
    want[2] = 3;
    for (int k = 0; k < 40 && n_to == 0; k++) cycle();
    check_eq("s3_timeout", 32'(n_to != 0), 32'd1);
    for (int k = 0; k < 60 && log_sig[11:8] == 4'd0; k++) cycle();
    want[0] = 2;
    drain("s3_done", 60);
    check_eq("s3_order", log_sig, 32'h131);

    // Owner 2 releases with 0 and 1 waiting: pointer wraps to 0.
    log_sig = 32'd0; want[2] = 3;
    for (int k = 0; k < 10 && gnt != 3'b100; k++) cycle();
    want[0] = 2; want[1] = 2;
    drain("s4_done", 60);
    check_eq("s4_order", log_sig, 32'h312);

    // Reset in the middle of a read burst.
    want[0] = 6;
    for (int k = 0; k < 10 && rx_buf_rden !== 1'b1; k++) cycle();
    check_eq("pre_rst_rden", 32'(rx_buf_rden), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    clear_model();
    req = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    log_sig = 32'd0; want[1] = 2; want[2] = 2;
    drain("s5_done", 40);
    check_eq("s5_order", log_sig, 32'h23);

    // Random stress with random addresses, early drops and over-long bursts.
    rnd_addr = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (want[i] == 0 && $urandom_range(0, 7) == 0) want[i] = int'($urandom_range(1, 14));
        else if (want[i] > 0 && $urandom_range(0, 31) == 0) want[i] = 0;
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) want[i] = 0;
    drain("stress_done", 40);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_buf_arb.md
RX_BUF_ARB -- requirements
Module: rx_buf_arb

Interface
REQ-001 Parameter MAX_HOLD, default 2047: max consecutive GRANT cycles per tenure; legal range 1..2047; counter width 11 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  per-requester access request; bit i held high for whole burst.
REQ-005 raddr0, raddr1, raddr2  input  11 each  read address from requester 0/1/2.
REQ-006 gnt  output  3  one-hot (or zero) grant, registered.
REQ-007 rx_buf_rden  output  1  registered read enable to rx buffer RAM.
REQ-008 rx_buf_raddr  output  11  registered read address to rx buffer RAM.
REQ-009 rx_buf_rdata  input  8  RAM read data, valid one cycle after rx_buf_rden.
REQ-010 rdata  output  8  rx_buf_rdata passed through combinationally.
REQ-011 rdata_vld  output  3  one-hot pulse marking rdata valid for the owning requester.
REQ-012 hold_timeout  output  1  one-cycle pulse when a tenure is forcibly ended.

Function
REQ-013 Sole owner of the rx buffer read port; replaces OR-merging of requester enables/addresses; at most one requester accesses the RAM per cycle.
REQ-014 FSM states: IDLE, GRANT.
REQ-015 IDLE: if req==0, stay IDLE, gnt=0; else select winner, go GRANT next cycle with gnt[winner]=1.
REQ-016 Winner = first set req bit searching round-robin from pointer ptr (2 bits, values 0..2), order ptr, ptr+1, ptr+2 mod 3.
REQ-017 GRANT with owner g: each cycle rx_buf_rden <= req[g], rx_buf_raddr <= raddr_g if req[g] else 0.
REQ-018 GRANT exit on req[g]==0: next state IDLE, gnt <= 0, ptr <= (g+1) mod 3, rx_buf_rden <= 0.
REQ-019 Hold counter cleared on GRANT entry, increments each GRANT cycle; at count==MAX_HOLD-1 with req[g] still high: next state IDLE, gnt <= 0, ptr <= (g+1) mod 3, hold_timeout pulses 1 cycle, rx_buf_rden <= 0.
REQ-020 After timeout, the same requester re-competes normally from IDLE; no lockout.
REQ-021 Latency: req rises cycle N (IDLE) -> gnt at N+1 -> first rden/raddr at N+2 -> rdata_vld[g] at N+3.
REQ-022 rdata_vld <= one-hot of owner when rx_buf_rden==1 else 0, one cycle delayed; reads issued in the last GRANT cycle still produce rdata_vld after gnt drops.
REQ-023 IDLE always: rx_buf_rden=0, rx_buf_raddr=0, gnt=0.
REQ-024 Minimum one IDLE cycle between tenures; no back-to-back grant handover.
REQ-025 req bits of non-owners ignored during GRANT; changes of raddr_g honoured every cycle.
REQ-026 Invalid ptr encoding (3) treated as 0.

Reset
REQ-027 reset low: state=IDLE, ptr=0, hold counter=0, gnt=0, rx_buf_rden=0, rx_buf_raddr=0, rdata_vld=0, hold_timeout=0, immediately and asynchronously.
REQ-028 reset mid-GRANT aborts tenure; pending rdata_vld suppressed; first post-reset winner searched from requester 0.

Verification
REQ-029 req=3'b111 from cycle 0, each drops after 4 reads -> grants in order 0,1,2; each gets exactly 4 rdata_vld pulses; one IDLE cycle between tenures.
REQ-030 req[1] high alone at cycle N, raddr1=0x010..0x013 incrementing -> gnt=3'b010 at N+1, rden with raddr 0x010 at N+2, rdata_vld=3'b010 at N+3..N+6.
REQ-031 MAX_HOLD=8, req[0] held forever, req[2] high -> hold_timeout at 8th GRANT cycle, then gnt=3'b100, then requester 0 re-granted after req[2] drops.
REQ-032 Owner 2 releases while req[0] and req[1] high -> next grant to 0 (ptr wrap 2->0).
REQ-033 reset asserted during GRANT with rden=1 -> all outputs 0 same cycle; after release, req=3'b110 -> grant to 1.
REQ-034 Random req/raddr stress, 10k cycles -> gnt never multi-hot, rden only during GRANT, every rden followed by exactly one rdata_vld to owner.
